pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Supervises the audio-clock PLL from its reference side: drives the PLL's active-high reset, consumes its asynchronous `locked` output, and releases the mic-array datapath reset only after lock has been stable. Runs on the free-running 12.5 MHz reference clock, so it keeps working while the PLL output is absent. Counts loss-of-lock events for status readout. Optionally retries the PLL on lock timeout.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops on `pll_locked`.
- FILTER_CYCLES, 16: consecutive synchronized-high cycles required to accept lock.
- HOLDOFF_CYCLES, 1024: additional stable-lock cycles before releasing `sys_reset_n`.
- PLL_RST_CYCLES, 16: width of each `pll_rst` pulse.
- LOCK_TIMEOUT_CYCLES, 125000: 10 ms wait for lock (retry build only).
- MAX_RETRIES, 7: PLL resets attempted before declaring failure (retry build only).

Ports:
- clk  in  1  free-running reference clock (same source as the PLL refclk).
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- pll_locked  in  1  PLL lock indicator, asynchronous to `clk`.
- clear_sticky  in  1  single-cycle pulse, clears `lock_lost_sticky`.
- pll_rst  out  1  active-high PLL reset.
- sys_reset_n  out  1  active-low reset for the audio datapath.
- status_locked  out  1  high in RUN.
- lock_lost_sticky  out  1  set on any loss of lock in RUN.
- lost_count  out  8  saturating loss-of-lock counter.
- retry_count  out  4  PLL resets issued since reset_n (0 without retry).
- pll_fail  out  1  retries exhausted (0 without retry).

## Operation
- `pll_locked` passes through SYNC_STAGES flops -> `lock_s`.
- Filter: counter increments while `lock_s`=1 and saturates at FILTER_CYCLES; `lock_f`=1 when saturated. `lock_s`=0 clears the counter and `lock_f` in the same cycle, so loss is detected without delay.
- States:
  - PLLRST: `pll_rst`=1 for PLL_RST_CYCLES, then WAIT_LOCK.
  - WAIT_LOCK: `lock_f`=1 -> HOLDOFF.
  - HOLDOFF: count HOLDOFF_CYCLES. `lock_f`=0 -> WAIT_LOCK with the counter cleared. Count done -> RUN.
  - RUN: `sys_reset_n`=1, `status_locked`=1. `lock_f`=0 -> LOST.
  - LOST: one cycle. `lost_count`++ (saturates at 255), set sticky, then WAIT_LOCK. PLL is not reset.
- `sys_reset_n`=0 in every state except RUN; it is registered and glitch-free.
- If `clear_sticky` and a set occur in the same cycle, the set wins.
- `reset_n` assertion mid-operation: immediate return to reset values, including `pll_rst`=1.

## Timing
- Reset values: state PLLRST; `pll_rst`=1, `sys_reset_n`=0, `status_locked`=0, `lock_lost_sticky`=0, `lost_count`=0, `retry_count`=0, `pll_fail`=0. All counters are 0.
- After `reset_n` deasserts, `pll_rst` stays high for exactly PLL_RST_CYCLES edges.
- Lock-acquire latency: `sys_reset_n` rises exactly SYNC_STAGES+FILTER_CYCLES+HOLDOFF_CYCLES edges after the first edge that samples `pll_locked`=1, given stable lock. Defaults give 1042 edges.
- Loss latency: `sys_reset_n` falls SYNC_STAGES+1 edges after the first edge sampling `pll_locked`=0. `lost_count` updates 1 edge later.
- A low glitch on `pll_locked` shorter than one clock period may be missed. Any glitch that is sampled restarts the filter.

## Configuration
- PLL_LOCK_SUPERVISOR_RETRY_EN defined:
  - WAIT_LOCK counts up to LOCK_TIMEOUT_CYCLES. On timeout: if `retry_count`<MAX_RETRIES, increment it and go to PLLRST; otherwise go to FAIL.
  - FAIL is terminal until `reset_n`: `pll_fail`=1, `pll_rst`=1, `sys_reset_n`=0.
- Undefined: no timeout counter and no FAIL state. WAIT_LOCK waits indefinitely. `retry_count` and `pll_fail` are tied to 0.

## Structure
- pll_supervisor_pkg: state enum (PLLRST, WAIT_LOCK, HOLDOFF, RUN, LOST, FAIL), default parameter constants, `lost_count` width.
- Sub-module lock_sync_filter: synchronizer plus filter, outputs `lock_f`.

## Test plan
Bench parameters: SYNC=2, FILTER=4, HOLDOFF=8, RST=3, TIMEOUT=20, MAX_RETRIES=2.
- Release `reset_n`, then assert `pll_locked` at edge 5 -> `pll_rst` high for 3 edges; `sys_reset_n` rises 14 edges after `pll_locked` is first sampled high; `status_locked`=1.
- In RUN, drop `pll_locked` for 3 cycles, then restore -> `sys_reset_n` low 3 edges after the drop; `lost_count`=1; sticky=1; `sys_reset_n` returns 14 edges after restore.
- Drop `pll_locked` for 1 cycle during HOLDOFF -> no release at the original time; full 14-edge sequence restarts; `lost_count` stays 0.
- Pulse `clear_sticky` in the same cycle as a new loss -> sticky remains 1. Clear on an idle cycle -> 0. 300 losses -> `lost_count`=255.
- RETRY_EN, `pll_locked` held low -> 3 `pll_rst` pulses of 3 cycles each, spaced by 20-cycle timeouts; `retry_count`=2; `pll_fail`=1; `pll_rst` stuck high.
- Without RETRY_EN, `pll_locked` low for 1000 cycles -> state stays WAIT_LOCK; `retry_count`=0; `pll_fail`=0.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
// Holds the state encoding and the status counter widths.
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLDOFF   = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_FILTER_CYCLES       = 16;
    localparam int DEF_HOLDOFF_CYCLES      = 1024;
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 125000;
    localparam int DEF_MAX_RETRIES         = 7;

    localparam int LOST_CNT_W  = 8;
    localparam int RETRY_CNT_W = 4;

endpackage

// File: rtl/lock_sync_filter.sv
// Synchronizes the asynchronous PLL lock flag and accepts it only after a
// run of consecutive high samples; any sampled low drops the result at once.
module lock_sync_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pll_locked,
    output logic o_lock_f
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FW-1:0]          r_filt_cnt;
    logic                   w_lock_s;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync     <= '0;
            r_filt_cnt <= '0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_pll_locked);
            if (!w_lock_s)
                r_filt_cnt <= '0;
            else if (r_filt_cnt != FW'(FILTER_CYCLES))
                r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    // Gated by the live synchronized bit so a sampled drop is seen without waiting for the counter clear.
    assign o_lock_f = w_lock_s && (r_filt_cnt == FW'(FILTER_CYCLES));

endmodule

// File: rtl/pll_lock_supervisor.sv
// Reference-clock PLL supervisor: PLL reset pulse, lock filtering, holdoff and
// datapath reset release. Define PLL_LOCK_SUPERVISOR_RETRY_EN for timeout retries.
module pll_lock_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES       = DEF_FILTER_CYCLES,
    parameter int HOLDOFF_CYCLES      = DEF_HOLDOFF_CYCLES,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_pll_locked,
    input  logic                   i_clear_sticky,
    output logic                   o_pll_rst,
    output logic                   o_sys_reset_n,
    output logic                   o_status_locked,
    output logic                   o_lock_lost_sticky,
    output logic [LOST_CNT_W-1:0]  o_lost_count,
    output logic [RETRY_CNT_W-1:0] o_retry_count,
    output logic                   o_pll_fail
);

    localparam int RST_W  = $clog2(PLL_RST_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    state_t                r_state;
    logic [RST_W-1:0]      r_rst_cnt;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic                  r_pll_rst;
    logic                  r_sys_reset_n;
    logic                  r_status_locked;
    logic                  r_sticky;
    logic [LOST_CNT_W-1:0] r_lost_count;
    logic                  w_lock_f;

`ifdef PLL_LOCK_SUPERVISOR_RETRY_EN
    localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]        r_to_cnt;
    logic [RETRY_CNT_W-1:0] r_retry_count;
    logic                   r_pll_fail;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{LOCK_TIMEOUT_CYCLES, MAX_RETRIES};
`endif

    lock_sync_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_lock_sync_filter (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_pll_locked (i_pll_locked),
        .o_lock_f     (w_lock_f)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= ST_PLLRST;
            r_rst_cnt       <= '0;
            r_hold_cnt      <= '0;
            r_pll_rst       <= 1'b1;
            r_sys_reset_n   <= 1'b0;
            r_status_locked <= 1'b0;
            r_sticky        <= 1'b0;
            r_lost_count    <= '0;
`ifdef PLL_LOCK_SUPERVISOR_RETRY_EN
            r_to_cnt        <= '0;
            r_retry_count   <= '0;
            r_pll_fail      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_PLLRST: begin
                    if (r_rst_cnt == RST_W'(PLL_RST_CYCLES - 1)) begin
                        r_rst_cnt <= '0;
                        r_pll_rst <= 1'b0;
                        r_state   <= ST_WAIT_LOCK;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                // The accepting edge already counts as the first holdoff cycle.
                ST_WAIT_LOCK: begin
                    if (w_lock_f) begin
                        r_hold_cnt <= HOLD_W'(1);
                        r_state    <= ST_HOLDOFF;
`ifdef PLL_LOCK_SUPERVISOR_RETRY_EN
                        r_to_cnt   <= '0;
                    end else if (r_to_cnt == TO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        r_to_cnt  <= '0;
                        r_pll_rst <= 1'b1;
                        if (r_retry_count < RETRY_CNT_W'(MAX_RETRIES)) begin
                            r_retry_count <= r_retry_count + 1'b1;
                            r_state       <= ST_PLLRST;
                        end else begin
                            r_pll_fail <= 1'b1;
                            r_state    <= ST_FAIL;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                ST_HOLDOFF: begin
                    if (!w_lock_f) begin
                        r_hold_cnt <= '0;
                        r_state    <= ST_WAIT_LOCK;
                    end else if (r_hold_cnt >= HOLD_W'(HOLDOFF_CYCLES - 1)) begin
                        r_hold_cnt      <= '0;
                        r_sys_reset_n   <= 1'b1;
                        r_status_locked <= 1'b1;
                        r_state         <= ST_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_lock_f) begin
                        r_sys_reset_n   <= 1'b0;
                        r_status_locked <= 1'b0;
                        r_state         <= ST_LOST;
                    end
                end
                ST_LOST: begin
                    if (r_lost_count != '1)
                        r_lost_count <= r_lost_count + 1'b1;
                    r_state <= ST_WAIT_LOCK;
                end
`ifdef PLL_LOCK_SUPERVISOR_RETRY_EN
                ST_FAIL: begin
                    r_pll_rst     <= 1'b1;
                    r_sys_reset_n <= 1'b0;
                end
`endif
                default: begin
                    r_rst_cnt       <= '0;
                    r_pll_rst       <= 1'b1;
                    r_sys_reset_n   <= 1'b0;
                    r_status_locked <= 1'b0;
                    r_state         <= ST_PLLRST;
                end
            endcase

            // A loss being recorded takes priority over a simultaneous clear request.
            if (r_state == ST_LOST)
                r_sticky <= 1'b1;
            else if (i_clear_sticky)
                r_sticky <= 1'b0;
        end
    end

    assign o_pll_rst          = r_pll_rst;
    assign o_sys_reset_n      = r_sys_reset_n;
    assign o_status_locked    = r_status_locked;
    assign o_lock_lost_sticky = r_sticky;
    assign o_lost_count       = r_lost_count;

`ifdef PLL_LOCK_SUPERVISOR_RETRY_EN
    assign o_retry_count = r_retry_count;
    assign o_pll_fail    = r_pll_fail;
`else
    assign o_retry_count = '0;
    assign o_pll_fail    = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
// Covers acquire, loss, holdoff glitch, sticky priority, saturation and timeout behaviour.
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       resetN;
    logic       pllLocked;
    logic       clearSticky;
    logic       pllRst;
    logic       sysResetN;
    logic       statusLocked;
    logic       lostSticky;
    logic [7:0] lostCount;
    logic [3:0] retryCount;
    logic       pllFail;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int   reps;
        logic locked;
        logic expRst;
        logic expSrn;
        logic expSticky;
        int   expLost;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .SYNC_STAGES         (2),
        .FILTER_CYCLES       (4),
        .HOLDOFF_CYCLES      (8),
        .PLL_RST_CYCLES      (3),
        .LOCK_TIMEOUT_CYCLES (20),
        .MAX_RETRIES         (2)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (resetN),
        .i_pll_locked       (pllLocked),
        .i_clear_sticky     (clearSticky),
        .o_pll_rst          (pllRst),
        .o_sys_reset_n      (sysResetN),
        .o_status_locked    (statusLocked),
        .o_lock_lost_sticky (lostSticky),
        .o_lost_count       (lostCount),
        .o_retry_count      (retryCount),
        .o_pll_fail         (pllFail)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic locked, input logic clr);
        pllLocked   = locked;
        clearSticky = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle lock drop from RUN; optionally pulses clear on the edge that records the loss.
    task automatic lossSequence(input logic clrOnLost, input string tag);
        applyStimulus(1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput({tag, "_srn_still_high"}, int'(sysResetN), 1);
        tick();
        checkOutput({tag, "_srn_fell"}, int'(sysResetN), 0);
        applyStimulus(1'b1, clrOnLost);
        tick();
        applyStimulus(1'b1, 1'b0);
    endtask

    function automatic logic expRetryRst(input int e);
        return (e <= 2) || (e >= 23 && e <= 25) || (e >= 46 && e <= 48) || (e >= 69);
    endfunction

    function automatic int expRetryCount(input int e);
        return (e < 23) ? 0 : ((e < 46) ? 1 : 2);
    endfunction

    initial begin
        vecs[0] = '{2,  1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[1] = '{2,  1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{13, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[3] = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[4] = '{2,  1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[5] = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[6] = '{13, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[7] = '{6,  1'b1, 1'b0, 1'b1, 1'b1, 1};

        resetN = 1'b0;
        applyStimulus(1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("rst_pll_rst", int'(pllRst), 1);
        checkOutput("rst_sys_reset_n", int'(sysResetN), 0);
        checkOutput("rst_status_locked", int'(statusLocked), 0);
        checkOutput("rst_sticky", int'(lostSticky), 0);
        checkOutput("rst_lost_count", int'(lostCount), 0);
        checkOutput("rst_retry_count", int'(retryCount), 0);
        checkOutput("rst_pll_fail", int'(pllFail), 0);

        // Acquire, 3-cycle loss and reacquire, one row per run of identical edges.
        resetN = 1'b1;
        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                applyStimulus(vecs[v].locked, 1'b0);
                tick();
                checkOutput($sformatf("vec%0d_%0d_pll_rst", v, r), int'(pllRst), int'(vecs[v].expRst));
                checkOutput($sformatf("vec%0d_%0d_srn", v, r), int'(sysResetN), int'(vecs[v].expSrn));
                checkOutput($sformatf("vec%0d_%0d_status", v, r), int'(statusLocked), int'(vecs[v].expSrn));
                checkOutput($sformatf("vec%0d_%0d_sticky", v, r), int'(lostSticky), int'(vecs[v].expSticky));
                checkOutput($sformatf("vec%0d_%0d_lost", v, r), int'(lostCount), vecs[v].expLost);
            end
        end

        // Asynchronous reset in RUN returns outputs to reset values without a clock edge.
        resetN = 1'b0;
        #2;
        checkOutput("async_rst_pll_rst", int'(pllRst), 1);
        checkOutput("async_rst_srn", int'(sysResetN), 0);
        checkOutput("async_rst_status", int'(statusLocked), 0);
        checkOutput("async_rst_sticky", int'(lostSticky), 0);
        checkOutput("async_rst_lost", int'(lostCount), 0);
        tick();

        // Single-cycle drop during HOLDOFF restarts the whole acquire sequence.
        applyStimulus(1'b1, 1'b0);
        resetN = 1'b1;
        repeat (8) tick();
        applyStimulus(1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0);
        repeat (5) tick();
        checkOutput("holdoff_glitch_no_release_e14", int'(sysResetN), 0);
        repeat (8) tick();
        checkOutput("holdoff_glitch_no_release_e22", int'(sysResetN), 0);
        tick();
        checkOutput("holdoff_glitch_release_e23", int'(sysResetN), 1);
        checkOutput("holdoff_glitch_status", int'(statusLocked), 1);
        checkOutput("holdoff_glitch_lost", int'(lostCount), 0);

        lossSequence(1'b0, "loss1");
        checkOutput("loss1_sticky", int'(lostSticky), 1);
        checkOutput("loss1_lost", int'(lostCount), 1);
        repeat (16) tick();
        checkOutput("loss1_relock_srn", int'(sysResetN), 1);

        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("idle_clear_sticky", int'(lostSticky), 0);

        lossSequence(1'b1, "loss2");
        checkOutput("set_beats_clear_sticky", int'(lostSticky), 1);
        checkOutput("loss2_lost", int'(lostCount), 2);
        repeat (16) tick();

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0);
            tick();
            applyStimulus(1'b1, 1'b0);
            repeat (19) tick();
        end
        checkOutput("lost_count_saturated", int'(lostCount), 255);
        checkOutput("after_many_losses_srn", int'(sysResetN), 1);

        // Lock never arrives.
        resetN = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("noLock_rst_lost", int'(lostCount), 0);
        tick();
        resetN = 1'b1;
`ifdef PLL_LOCK_SUPERVISOR_RETRY_EN
        for (int e = 1; e <= 100; e++) begin
            tick();
            checkOutput($sformatf("retry_e%0d_pll_rst", e), int'(pllRst), int'(expRetryRst(e)));
            checkOutput($sformatf("retry_e%0d_count", e), int'(retryCount), expRetryCount(e));
            checkOutput($sformatf("retry_e%0d_fail", e), int'(pllFail), (e >= 69) ? 1 : 0);
            checkOutput($sformatf("retry_e%0d_srn", e), int'(sysResetN), 0);
        end
`else
        for (int e = 1; e <= 1000; e++) begin
            tick();
            if (e == 2 || e == 3 || e == 1000) begin
                checkOutput($sformatf("noretry_e%0d_pll_rst", e), int'(pllRst), (e <= 2) ? 1 : 0);
            end
        end
        checkOutput("noretry_srn", int'(sysResetN), 0);
        checkOutput("noretry_status", int'(statusLocked), 0);
        checkOutput("noretry_retry_count", int'(retryCount), 0);
        checkOutput("noretry_pll_fail", int'(pllFail), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
